// File: rtl/div_4bit_seq.sv
// 4-bit unsigned restoring divider built around a single ripple subtractor.
// One trial subtraction per cycle; quotient/remainder after four iterations.

// 4-bit ripple-borrow subtractor: diff = a - b, borrow set when a < b.
module sub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       borrow
);

  logic [4:0] bw;

  // Ripple the borrow from bit 0 upward.
  always_comb begin
    bw    = '0;
    diff  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      diff[i]  = a[i] ^ b[i] ^ bw[i];
      bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
    borrow = bw[4];
  end

endmodule

module div_4bit_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] q_reg, r_reg, d_reg;
  logic [1:0] cnt;

  logic [4:0] s;
  logic [3:0] diff;
  logic       borrow;
  logic       trial_neg;
  logic [3:0] q_next, r_next;

  // Partial remainder shifted left with the next dividend bit.
  assign s = {r_reg, q_reg[3]};

  sub_4bit u_sub (
    .a      (s[3:0]),
    .b      (d_reg),
    .diff   (diff),
    .borrow (borrow)
  );

  // A set S[4] means S >= 16 > D, so the trial can only go negative below that.
  always_comb begin
    trial_neg = ~s[4] & borrow;
    if (trial_neg) begin
      r_next = s[3:0];
      q_next = {q_reg[2:0], 1'b0};
    end else begin
      r_next = diff;
      q_next = {q_reg[2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (divisor == 4'd0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt == 2'd3) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= (divisor == 4'd0);
            if (divisor == 4'd0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Scoreboard bench for div_4bit_seq: driver pushes expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_div_4bit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  div_4bit_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned z;
    int unsigned lat;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned n_done  = 0;
  int unsigned n_expected_done = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain division, with the zero-divisor rule.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned c);
    exp_t e;
    if (b == 0) begin
      e.q = 15; e.r = a; e.z = 1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 0; e.lat = 5;
    end
    e.acc_cyc = c;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      check("done_single_cycle", prev_done, 0);
      check("busy_with_done", busy, 1);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.z);
        check("latency", cyc - e.acc_cyc, e.lat);
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int unsigned k = 0;
    @(negedge clk);
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Present an operation at a negedge while idle; it is accepted on the next posedge.
  task automatic issue(input int unsigned a, input int unsigned b, input bit hold,
                       output int unsigned acc);
    wait_idle();
    dividend = 4'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    acc      = cyc;
    sb.push_back(model(a, b, cyc));
    n_expected_done++;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned acc, prev_acc, prev_lat, bc;
    int unsigned ops[4][2];
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // 13/3 with busy-duration measurement
    issue(13, 3, 0, acc);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    check("busy_cycles", bc, 5);
    drain();

    ops = '{'{15, 1}, '{3, 9}, '{14, 15}, '{15, 8}};
    foreach (ops[i]) issue(ops[i][0], ops[i][1], 0, acc);
    drain();

    // divide by zero then a normal op
    issue(7, 0, 0, acc);
    issue(9, 2, 0, acc);
    drain();

    // start pulses during RUN and DONE must be ignored
    issue(12, 5, 0, acc);
    @(negedge clk);
    dividend = 4'd1; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int unsigned k = 0;
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("no_extra_done", n_done, n_expected_done);

    // reset during the second RUN cycle aborts the operation
    issue(11, 2, 0, acc);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    n_expected_done--;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    rst = 1'b0;
    issue(11, 2, 0, acc);
    drain();

    // random gaps and operands
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue($urandom_range(0, 15), $urandom_range(0, 15), 0, acc);
      if ($urandom_range(0, 1) == 1) begin
        dividend = 4'($urandom); divisor = 4'($urandom);
      end
    end
    drain();

    // exhaustive with start held high; check throughput too
    prev_acc = 0; prev_lat = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(a, b, 1, acc);
        if (!(a == 0 && b == 0))
          check("throughput", acc - prev_acc, prev_lat + 1);
        prev_acc = acc;
        prev_lat = (b == 0) ? 1 : 5;
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    check("done_count", n_done, n_expected_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
